// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the RV32I multi-cycle control unit.
// Contents: opcode constants, ALU_CTRL / ALU_SRC_A / ALU_SRC_B / RESULT_SRC
// encodings, FSM state constants, the ALU-control op-class enum and the
// branch-condition helper.
package mc_control_fsm_pkg;

    // Major opcodes (IR[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ALU operation encodings
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // ALU operand and result mux selects
    localparam logic [1:0] SRCA_PC     = 2'd0;
    localparam logic [1:0] SRCA_OLDPC  = 2'd1;
    localparam logic [1:0] SRCA_RS1    = 2'd2;
    localparam logic [1:0] SRCA_ZERO   = 2'd3;
    localparam logic [1:0] SRCB_RS2    = 2'd0;
    localparam logic [1:0] SRCB_IMM    = 2'd1;
    localparam logic [1:0] SRCB_FOUR   = 2'd2;
    localparam logic [1:0] RES_ALUOUT  = 2'd0;
    localparam logic [1:0] RES_MEMDATA = 2'd1;
    localparam logic [1:0] RES_ALU     = 2'd2;

    // FSM states; all 16 codes of the 4-bit register are in use
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEMADR   = 4'd3;
    localparam logic [3:0] S_MEMREAD  = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_MEMWRITE = 4'd6;
    localparam logic [3:0] S_EXEC_R   = 4'd7;
    localparam logic [3:0] S_EXEC_I   = 4'd8;
    localparam logic [3:0] S_ALUWB    = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JAL      = 4'd11;
    localparam logic [3:0] S_JALR     = 4'd12;
    localparam logic [3:0] S_LUI      = 4'd13;
    localparam logic [3:0] S_AUIPC    = 4'd14;
    localparam logic [3:0] S_HALT     = 4'd15;

    // Which decode table the ALU-control decoder should apply
    typedef enum logic [1:0] {
        OPC_ADD    = 2'd0,
        OPC_RTYPE  = 2'd1,
        OPC_ITYPE  = 2'd2,
        OPC_BRANCH = 2'd3
    } op_class_t;

    // Branch condition from FUNCT3 and the ALU flags; 010/011 never branch
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zero,
                                          input logic       lt);
        case (funct3)
            3'b000:         branch_taken = zero;
            3'b001:         branch_taken = !zero;
            3'b100, 3'b110: branch_taken = lt;
            3'b101, 3'b111: branch_taken = !lt;
            default:        branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm_alu_ctrl_dec.sv
// alu_ctrl_dec: combinational ALU-control decoder.
// Ports:
//   op_class_i  - decode table to use (forced ADD, R-type, I-type, branch)
//   funct3_i    - IR[14:12]
//   funct7b5_i  - IR[30]
//   alu_ctrl_o  - ALU operation code
module alu_ctrl_dec
    import mc_control_fsm_pkg::*;
(
    input  op_class_t  op_class_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [3:0] alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (op_class_i)
            OPC_RTYPE, OPC_ITYPE: begin
                case (funct3_i)
                    // IR[30] of an I-type addi is immediate data, so SUB is R-type only
                    3'b000: alu_ctrl_o = (op_class_i == OPC_RTYPE && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_ctrl_o = ALU_SLL;
                    3'b010: alu_ctrl_o = ALU_SLT;
                    3'b011: alu_ctrl_o = ALU_SLTU;
                    3'b100: alu_ctrl_o = ALU_XOR;
                    3'b101: alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110: alu_ctrl_o = ALU_OR;
                    3'b111: alu_ctrl_o = ALU_AND;
                    default: alu_ctrl_o = ALU_ADD;
                endcase
            end
            OPC_BRANCH: begin
                // beq/bne compare by subtraction; the unused 010/011 codes fall in here too
                case (funct3_i[2:1])
                    2'b10:   alu_ctrl_o = ALU_SLT;
                    2'b11:   alu_ctrl_o = ALU_SLTU;
                    default: alu_ctrl_o = ALU_SUB;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control unit for the Aristotle RV32I datapath.
// Sequences fetch / decode / execute / memory / writeback, drives datapath
// selects and enables, handshakes with unified memory and counts cycles and
// retired instructions.
// Ports:
//   CLK, RST            - clock (rising edge), asynchronous active-low reset
//   OPCODE, FUNCT3,
//   FUNCT7B5            - instruction register fields
//   ZERO, LT            - ALU flags used for branch resolution
//   MEM_RDY             - memory completes the current request this cycle
//   MEM_REQ, MEM_WE,
//   ADDR_SRC            - memory request, write flag, address select
//   IR_WRITE, PC_WRITE,
//   REG_WRITE           - datapath write enables
//   ALU_SRC_A/B,
//   ALU_CTRL,
//   RESULT_SRC          - datapath mux selects and ALU operation
//   EOP, ILLEGAL        - sticky end-of-program and illegal-opcode flags
//   CYCLE_CNT,
//   INSTR_CNT           - active-cycle and retired-instruction counters
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [6:0]       OPCODE,
    input  logic [2:0]       FUNCT3,
    input  logic             FUNCT7B5,
    input  logic             ZERO,
    input  logic             LT,
    input  logic             MEM_RDY,
    output logic             MEM_REQ,
    output logic             MEM_WE,
    output logic             ADDR_SRC,
    output logic             IR_WRITE,
    output logic             PC_WRITE,
    output logic             REG_WRITE,
    output logic [1:0]       ALU_SRC_A,
    output logic [1:0]       ALU_SRC_B,
    output logic [3:0]       ALU_CTRL,
    output logic [1:0]       RESULT_SRC,
    output logic             EOP,
    output logic             ILLEGAL,
    output logic [CNT_W-1:0] CYCLE_CNT,
    output logic [CNT_W-1:0] INSTR_CNT
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;
    op_class_t        op_class;

    alu_ctrl_dec u_alu_ctrl_dec (
        .op_class_i (op_class),
        .funct3_i   (FUNCT3),
        .funct7b5_i (FUNCT7B5),
        .alu_ctrl_o (ALU_CTRL)
    );

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (MEM_RDY) state_d = S_DECODE;
            S_DECODE: begin
                case (OPCODE)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    OP_SYSTEM:         state_d = S_HALT;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (OPCODE == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (MEM_RDY) state_d = S_MEMWB;
            S_MEMWRITE: if (MEM_RDY) state_d = S_FETCH;
            S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
            S_HALT:     state_d = S_HALT;
            // MEMWB, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC all finish the instruction
            default:    state_d = S_FETCH;
        endcase
    end

    // Output decode from the state register and IR fields. The FETCH write
    // strobes follow MEM_RDY so IR and PC capture in the same cycle the
    // memory completes; the branch PC_WRITE follows the ALU flags.
    always_comb begin
        MEM_REQ    = 1'b0;
        MEM_WE     = 1'b0;
        ADDR_SRC   = 1'b0;
        IR_WRITE   = 1'b0;
        PC_WRITE   = 1'b0;
        REG_WRITE  = 1'b0;
        ALU_SRC_A  = SRCA_PC;
        ALU_SRC_B  = SRCB_RS2;
        RESULT_SRC = RES_ALUOUT;
        op_class   = OPC_ADD;
        case (state_q)
            S_FETCH: begin
                MEM_REQ   = 1'b1;
                ALU_SRC_B = SRCB_FOUR;
                IR_WRITE  = MEM_RDY;
                PC_WRITE  = MEM_RDY;
            end
            S_DECODE: begin
                ALU_SRC_A = SRCA_OLDPC;
                ALU_SRC_B = SRCB_IMM;
            end
            S_MEMADR: begin
                ALU_SRC_A = SRCA_RS1;
                ALU_SRC_B = SRCB_IMM;
            end
            S_MEMREAD: begin
                MEM_REQ  = 1'b1;
                ADDR_SRC = 1'b1;
            end
            S_MEMWB: begin
                REG_WRITE  = 1'b1;
                RESULT_SRC = RES_MEMDATA;
            end
            S_MEMWRITE: begin
                MEM_REQ  = 1'b1;
                MEM_WE   = 1'b1;
                ADDR_SRC = 1'b1;
            end
            S_EXEC_R: begin
                ALU_SRC_A = SRCA_RS1;
                op_class  = OPC_RTYPE;
            end
            S_EXEC_I: begin
                ALU_SRC_A = SRCA_RS1;
                ALU_SRC_B = SRCB_IMM;
                op_class  = OPC_ITYPE;
            end
            S_ALUWB: REG_WRITE = 1'b1;
            S_BRANCH: begin
                ALU_SRC_A = SRCA_RS1;
                op_class  = OPC_BRANCH;
                PC_WRITE  = branch_taken(FUNCT3, ZERO, LT);
            end
            S_JAL: begin
                ALU_SRC_A  = SRCA_OLDPC;
                ALU_SRC_B  = SRCB_FOUR;
                RESULT_SRC = RES_ALU;
                REG_WRITE  = 1'b1;
                PC_WRITE   = 1'b1;
            end
            S_JALR: begin
                ALU_SRC_A  = SRCA_RS1;
                ALU_SRC_B  = SRCB_IMM;
                RESULT_SRC = RES_ALU;
                REG_WRITE  = 1'b1;
                PC_WRITE   = 1'b1;
            end
            S_LUI: begin
                ALU_SRC_A  = SRCA_ZERO;
                ALU_SRC_B  = SRCB_IMM;
                RESULT_SRC = RES_ALU;
                REG_WRITE  = 1'b1;
            end
            S_AUIPC: begin
                ALU_SRC_A  = SRCA_OLDPC;
                ALU_SRC_B  = SRCB_IMM;
                RESULT_SRC = RES_ALU;
                REG_WRITE  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            illegal_q   <= 1'b0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            if (state_q != S_IDLE && state_q != S_HALT)
                cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
            // Retire on entry to FETCH from a finishing state (not the IDLE start, not a FETCH stall)
            if (state_d == S_FETCH && state_q != S_IDLE && state_q != S_FETCH)
                instr_cnt_q <= instr_cnt_q + CNT_ONE;
        end
    end

    assign EOP       = (state_q == S_HALT);
    assign ILLEGAL   = illegal_q;
    assign CYCLE_CNT = cycle_cnt_q;
    assign INSTR_CNT = instr_cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction-level model expands each directed
// instruction into the per-cycle output sequence it must produce; every
// cycle is compared, plus hand-computed literal checkpoints.
module tb_mc_control_fsm;

    logic        CLK = 1'b0;
    logic        RST;
    logic [6:0]  OPCODE;
    logic [2:0]  FUNCT3;
    logic        FUNCT7B5, ZERO, LT, MEM_RDY;
    logic        MEM_REQ, MEM_WE, ADDR_SRC, IR_WRITE, PC_WRITE, REG_WRITE;
    logic [1:0]  ALU_SRC_A, ALU_SRC_B, RESULT_SRC;
    logic [3:0]  ALU_CTRL;
    logic        EOP, ILLEGAL;
    logic [31:0] CYCLE_CNT, INSTR_CNT;

    mc_control_fsm #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT3(FUNCT3), .FUNCT7B5(FUNCT7B5),
        .ZERO(ZERO), .LT(LT), .MEM_RDY(MEM_RDY), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
        .ADDR_SRC(ADDR_SRC), .IR_WRITE(IR_WRITE), .PC_WRITE(PC_WRITE), .REG_WRITE(REG_WRITE),
        .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .ALU_CTRL(ALU_CTRL),
        .RESULT_SRC(RESULT_SRC), .EOP(EOP), .ILLEGAL(ILLEGAL),
        .CYCLE_CNT(CYCLE_CNT), .INSTR_CNT(INSTR_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [6:0] op;  logic [2:0] f3;  logic f7;  logic rdy, zero, lt;
        logic req, we, asrc, irw, pcw, rw, eop, ill;
        logic [1:0] sa, sb, rs;  logic [3:0] ctl;
        int cyc, icnt;
    } rec_t;

    rec_t q[$];
    int   checks = 0, failures = 0;
    int   m_cyc = 0, m_icnt = 0;
    logic [6:0] m_op;  logic [2:0] m_f3;  logic m_f7, m_z, m_lt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic rec_t blank();
        rec_t r;
        r.op = m_op; r.f3 = m_f3; r.f7 = m_f7; r.zero = m_z; r.lt = m_lt; r.rdy = 1'b1;
        r.req = 0; r.we = 0; r.asrc = 0; r.irw = 0; r.pcw = 0; r.rw = 0; r.eop = 0; r.ill = 0;
        r.sa = 0; r.sb = 0; r.rs = 0; r.ctl = 0; r.cyc = 0; r.icnt = 0;
        return r;
    endfunction

    // ALU op for arithmetic instructions: base op by funct3, IR[30] picks SUB/SRA
    function automatic logic [3:0] alu_of(input bit is_r, input logic [2:0] f3, input logic f7);
        logic [3:0] base;
        case (f3)
            3'd0: base = 4'd0;  3'd1: base = 4'd2;  3'd2: base = 4'd3;  3'd3: base = 4'd4;
            3'd4: base = 4'd5;  3'd5: base = 4'd6;  3'd6: base = 4'd8;  default: base = 4'd9;
        endcase
        if (f7 && (f3 == 3'd5 || (f3 == 3'd0 && is_r))) base = base + 4'd1;
        return base;
    endfunction

    // Active cycle: stamp the counter values visible during it, then count it
    task automatic push(input rec_t r);
        r.cyc = m_cyc; r.icnt = m_icnt; m_cyc++;
        q.push_back(r);
    endtask

    task automatic add_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input int fw, input int mw, input logic z, input logic lt);
        rec_t r;
        m_op = op; m_f3 = f3; m_f7 = f7; m_z = z; m_lt = lt;
        for (int i = 0; i <= fw; i++) begin
            r = blank(); r.req = 1; r.sb = 2; r.rdy = (i == fw); r.irw = r.rdy; r.pcw = r.rdy;
            push(r);
        end
        r = blank(); r.sa = 1; r.sb = 1; push(r);
        case (op)
            7'b0000011, 7'b0100011: begin
                r = blank(); r.sa = 2; r.sb = 1; push(r);
                for (int i = 0; i <= mw; i++) begin
                    r = blank(); r.req = 1; r.asrc = 1; r.we = (op == 7'b0100011); r.rdy = (i == mw);
                    push(r);
                end
                if (op == 7'b0000011) begin r = blank(); r.rw = 1; r.rs = 1; push(r); end
            end
            7'b0110011, 7'b0010011: begin
                r = blank(); r.sa = 2; r.sb = (op == 7'b0010011) ? 2'd1 : 2'd0;
                r.ctl = alu_of(op == 7'b0110011, f3, f7); push(r);
                r = blank(); r.rw = 1; push(r);
            end
            7'b1100011: begin
                r = blank(); r.sa = 2;
                r.ctl = (f3[2] == 1'b0) ? 4'd1 : (f3[1] ? 4'd4 : 4'd3);
                case (f3)
                    3'd0: r.pcw = z;      3'd1: r.pcw = !z;
                    3'd4, 3'd6: r.pcw = lt;  3'd5, 3'd7: r.pcw = !lt;
                    default: r.pcw = 0;
                endcase
                push(r);
            end
            7'b1101111: begin r = blank(); r.sa = 1; r.sb = 2; r.rs = 2; r.rw = 1; r.pcw = 1; push(r); end
            7'b1100111: begin r = blank(); r.sa = 2; r.sb = 1; r.rs = 2; r.rw = 1; r.pcw = 1; push(r); end
            7'b0110111: begin r = blank(); r.sa = 3; r.sb = 1; r.rs = 2; r.rw = 1; push(r); end
            7'b0010111: begin r = blank(); r.sa = 1; r.sb = 1; r.rs = 2; r.rw = 1; push(r); end
            default: begin
                // Program ends: counters freeze, flags stay set
                for (int i = 0; i < 4; i++) begin
                    r = blank(); r.eop = 1; r.ill = (op != 7'b1110011);
                    r.cyc = m_cyc; r.icnt = m_icnt; q.push_back(r);
                end
                return;
            end
        endcase
        m_icnt++;
    endtask

    task automatic compare(input rec_t r);
        chk("MEM_REQ",    32'(MEM_REQ),    32'(r.req));
        chk("MEM_WE",     32'(MEM_WE),     32'(r.we));
        chk("ADDR_SRC",   32'(ADDR_SRC),   32'(r.asrc));
        chk("IR_WRITE",   32'(IR_WRITE),   32'(r.irw));
        chk("PC_WRITE",   32'(PC_WRITE),   32'(r.pcw));
        chk("REG_WRITE",  32'(REG_WRITE),  32'(r.rw));
        chk("ALU_SRC_A",  32'(ALU_SRC_A),  32'(r.sa));
        chk("ALU_SRC_B",  32'(ALU_SRC_B),  32'(r.sb));
        chk("ALU_CTRL",   32'(ALU_CTRL),   32'(r.ctl));
        chk("RESULT_SRC", 32'(RESULT_SRC), 32'(r.rs));
        chk("EOP",        32'(EOP),        32'(r.eop));
        chk("ILLEGAL",    32'(ILLEGAL),    32'(r.ill));
        chk("CYCLE_CNT",  CYCLE_CNT,       32'(r.cyc));
        chk("INSTR_CNT",  INSTR_CNT,       32'(r.icnt));
    endtask

    // Apply up to n queued cycles (n < 0: all); inputs change 1 after the edge, outputs sampled at negedge
    task automatic run(input int n);
        rec_t r;
        int k = 0;
        while (q.size() > 0 && (n < 0 || k < n)) begin
            r = q.pop_front();
            @(posedge CLK); #1;
            OPCODE = r.op; FUNCT3 = r.f3; FUNCT7B5 = r.f7; ZERO = r.zero; LT = r.lt; MEM_RDY = r.rdy;
            @(negedge CLK);
            compare(r);
            k++;
        end
    endtask

    task automatic do_reset();
        rec_t z;
        m_op = 7'd0; m_f3 = 3'd0; m_f7 = 1'b0; m_z = 1'b0; m_lt = 1'b0;
        z = blank();
        q.delete();
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        chk("rst_MEM_REQ", 32'(MEM_REQ), 32'd0);
        chk("rst_MEM_WE",  32'(MEM_WE),  32'd0);
        chk("rst_EOP",     32'(EOP),     32'd0);
        chk("rst_ILLEGAL", 32'(ILLEGAL), 32'd0);
        chk("rst_CYCLE",   CYCLE_CNT,    32'd0);
        chk("rst_INSTR",   INSTR_CNT,    32'd0);
        repeat (2) begin
            @(negedge CLK); compare(z);
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(negedge CLK); compare(z);
        m_cyc = 0; m_icnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b0; OPCODE = '0; FUNCT3 = '0; FUNCT7B5 = 0; ZERO = 0; LT = 0; MEM_RDY = 0;
        do_reset();

        // addi, no waits
        add_instr(7'b0010011, 3'b000, 1'b0, 0, 0, 0, 0);
        run(3);
        chk("addi_exec_ctl", 32'(ALU_CTRL), 32'd0);
        chk("addi_exec_rw",  32'(REG_WRITE), 32'd0);
        run(1);
        chk("addi_wb_rw",    32'(REG_WRITE), 32'd1);
        // lw, 2 fetch waits, 3 read waits
        add_instr(7'b0000011, 3'b010, 1'b0, 2, 3, 0, 0);
        run(1);
        chk("lw_f_instr", INSTR_CNT, 32'd1);
        chk("lw_f_cycle", CYCLE_CNT, 32'd4);
        chk("lw_f_req",   32'(MEM_REQ), 32'd1);
        chk("lw_f_irw",   32'(IR_WRITE), 32'd0);
        run(-1);
        // beq taken, bne not taken (both with ZERO=1)
        add_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1, 0);
        run(1);
        chk("beq_f_cycle", CYCLE_CNT, 32'd14);
        chk("beq_f_instr", INSTR_CNT, 32'd2);
        run(2);
        chk("beq_pcw", 32'(PC_WRITE), 32'd1);
        chk("beq_ctl", 32'(ALU_CTRL), 32'd1);
        add_instr(7'b1100011, 3'b001, 1'b0, 0, 0, 1, 0);
        run(3);
        chk("bne_pcw", 32'(PC_WRITE), 32'd0);
        chk("bne_ctl", 32'(ALU_CTRL), 32'd1);
        // sra (R, 101, IR30) and addi with IR30 set
        add_instr(7'b0110011, 3'b101, 1'b1, 0, 0, 0, 0);
        run(3);
        chk("sra_ctl", 32'(ALU_CTRL), 32'd7);
        run(-1);
        add_instr(7'b0010011, 3'b000, 1'b1, 1, 0, 0, 0);
        run(4);
        chk("addi30_ctl", 32'(ALU_CTRL), 32'd0);
        run(-1);
        // remaining instruction mix, model-checked every cycle
        add_instr(7'b0110011, 3'b000, 1'b1, 0, 0, 0, 0);  // sub
        add_instr(7'b0010011, 3'b101, 1'b1, 0, 0, 0, 0);  // srai
        add_instr(7'b0010011, 3'b101, 1'b0, 0, 0, 0, 0);  // srli
        add_instr(7'b0010011, 3'b010, 1'b0, 0, 0, 0, 0);  // slti
        add_instr(7'b0110011, 3'b111, 1'b0, 0, 0, 0, 0);  // and
        add_instr(7'b0100011, 3'b010, 1'b0, 1, 2, 0, 0);  // sw with waits
        add_instr(7'b1100011, 3'b100, 1'b0, 0, 0, 0, 1);  // blt taken
        add_instr(7'b1100011, 3'b111, 1'b0, 0, 0, 0, 1);  // bgeu not taken
        add_instr(7'b1100011, 3'b110, 1'b0, 0, 0, 1, 0);  // bltu not taken
        add_instr(7'b1100011, 3'b010, 1'b0, 0, 0, 1, 1);  // unused funct3: never taken
        add_instr(7'b1101111, 3'b000, 1'b0, 0, 0, 0, 0);  // jal
        add_instr(7'b1100111, 3'b000, 1'b0, 0, 0, 0, 0);  // jalr
        add_instr(7'b0110111, 3'b000, 1'b0, 0, 0, 0, 0);  // lui
        add_instr(7'b0010111, 3'b000, 1'b0, 0, 0, 0, 0);  // auipc
        add_instr(7'b0010011, 3'b000, 1'b0, 0, 0, 0, 0);
        run(-1);

        // addi then ecall: halts with counters frozen at 6 / 1
        do_reset();
        add_instr(7'b0010011, 3'b000, 1'b0, 0, 0, 0, 0);
        add_instr(7'b1110011, 3'b000, 1'b0, 0, 0, 0, 0);
        run(-1);
        chk("ecall_eop",   32'(EOP), 32'd1);
        chk("ecall_ill",   32'(ILLEGAL), 32'd0);
        chk("ecall_cycle", CYCLE_CNT, 32'd6);
        chk("ecall_instr", INSTR_CNT, 32'd1);

        // illegal opcode straight after reset
        do_reset();
        add_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 0, 0);
        run(-1);
        chk("illeg_eop",   32'(EOP), 32'd1);
        chk("illeg_ill",   32'(ILLEGAL), 32'd1);
        chk("illeg_cycle", CYCLE_CNT, 32'd2);

        // reset while a store is stalled in memory
        do_reset();
        add_instr(7'b0100011, 3'b010, 1'b0, 0, 5, 0, 0);
        run(5);
        chk("sw_stall_req", 32'(MEM_REQ), 32'd1);
        chk("sw_stall_we",  32'(MEM_WE), 32'd1);
        do_reset();
        add_instr(7'b0010011, 3'b000, 1'b0, 0, 0, 0, 0);
        run(1);
        chk("post_rst_req",   32'(MEM_REQ), 32'd1);
        chk("post_rst_cycle", CYCLE_CNT, 32'd0);
        chk("post_rst_instr", INSTR_CNT, 32'd0);
        run(-1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
